// File: rtl/sel_arb_pkg.sv
// Shared types and helpers for the sel_arb request selector.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sel_arb_pkg;

  typedef enum logic [1:0] {
    SEL_PRIORITY = 2'd0,
    SEL_UNIQUE   = 2'd1,
    SEL_RR       = 2'd2
  } sel_mode_e;

  // Callers zero-extend their vector to 64 bits; the channel count stays below that.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Highest set bit wins, which for a true one-hot vector is the only set bit.
  function automatic int unsigned onehot_to_idx(input logic [63:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sel_arb_pick.sv
// Circular first-match picker: scans req_i from start_i upward, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//   req_i   : request vector
//   start_i : index scanned first
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : index of the granted channel
//   any_o   : at least one request present
module sel_arb_pick
  import sel_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  int c;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(start_i) + k) % N;
      if (!any_o && req_i[c]) begin
        gnt_o[c] = 1'b1;
        any_o    = 1'b1;
      end
    end
  end

  assign idx_o = IW'(onehot_to_idx(64'(gnt_o)));

endmodule

// File: rtl/sel_arb.sv
// N-channel registered request selector (priority / unique / round-robin) with violation counters.
// Latency: one cycle from transfer to out_valid_o/out_data_o/out_ch_o.
// Backpressure: in_ready_o is zero while the output register holds data and out_ready_i is low.
//   clk_i, rst_ni           : clock, async active-low reset
//   in_valid_i/in_data_i    : per-channel requests, channel i at in_data_i[i*W +: W]
//   in_ready_o              : per-channel accept (combinational)
//   out_valid_o/out_data_o/out_ch_o/out_ready_i : registered output stage
//   clr_cnt_i               : synchronous clear of both counters
//   err_multi_o/err_none_o  : registered violation pulses (UNIQUE only)
//   multi_cnt_o/none_cnt_o  : saturating violation counts
module sel_arb
  import sel_arb_pkg::*;
#(
  parameter int           N           = 4,
  parameter int           W           = 8,
  parameter int           MODE        = 0,
  parameter int           FULL_CHK    = 1,
  parameter logic [W-1:0] DEFAULT_VAL = '0,
  parameter int           CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         in_valid_i,
  input  logic [N*W-1:0]       in_data_i,
  output logic [N-1:0]         in_ready_o,
  output logic                 out_valid_o,
  output logic [W-1:0]         out_data_o,
  output logic [$clog2(N)-1:0] out_ch_o,
  input  logic                 out_ready_i,
  input  logic                 clr_cnt_i,
  output logic                 err_multi_o,
  output logic                 err_none_o,
  output logic [CNT_W-1:0]     multi_cnt_o,
  output logic [CNT_W-1:0]     none_cnt_o
);

  localparam int              IW        = $clog2(N);
  localparam sel_mode_e       MODE_E    = sel_mode_e'(MODE[1:0]);
  localparam bit              IS_UNIQUE = (MODE_E == SEL_UNIQUE);
  localparam bit              IS_RR     = (MODE_E == SEL_RR);
  localparam logic [IW-1:0]   LAST_CH   = IW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [IW-1:0]    out_ch_q, out_ch_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             err_multi_q, err_multi_d;
  logic             err_none_q, err_none_d;
  logic [CNT_W-1:0] multi_cnt_q, multi_cnt_d;
  logic [CNT_W-1:0] none_cnt_q, none_cnt_d;

  logic             load;
  logic [IW-1:0]    start;
  logic [N-1:0]     pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  assign load = !out_valid_q || out_ready_i;

  // Round-robin resumes just past the last granted channel; rr_ptr resets to N-1 so ch0 leads.
  always_comb begin
    start = '0;
    if (IS_RR) start = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + 1'b1;
  end

  sel_arb_pick #(.N(N)) u_pick (
    .req_i   (in_valid_i),
    .start_i (start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign in_ready_o = load ? pick_gnt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      // An idle load slot empties the register but keeps the last data/channel visible.
      out_valid_d = pick_any;
      if (pick_any) begin
        out_data_d = in_data_i[int'(pick_idx)*W +: W];
        out_ch_d   = pick_idx;
        rr_ptr_d   = pick_idx;
      end
    end
  end

  // Violations are judged only when the stage can actually load.
  always_comb begin
    err_multi_d = IS_UNIQUE && load && (popcount(64'(in_valid_i)) > 1);
    err_none_d  = IS_UNIQUE && (FULL_CHK != 0) && load && (in_valid_i == '0);
  end

  // Counters move on the same edge that raises the pulse; clear still records a coincident event.
  always_comb begin
    multi_cnt_d = multi_cnt_q;
    none_cnt_d  = none_cnt_q;
    if (clr_cnt_i) begin
      multi_cnt_d = CNT_W'(err_multi_d);
      none_cnt_d  = CNT_W'(err_none_d);
    end else begin
      if (err_multi_d && (multi_cnt_q != CNT_MAX)) multi_cnt_d = multi_cnt_q + 1'b1;
      if (err_none_d && (none_cnt_q != CNT_MAX))   none_cnt_d  = none_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= DEFAULT_VAL;
      out_ch_q    <= '0;
      rr_ptr_q    <= LAST_CH;
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
      multi_cnt_q <= '0;
      none_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      err_multi_q <= err_multi_d;
      err_none_q  <= err_none_d;
      multi_cnt_q <= multi_cnt_d;
      none_cnt_q  <= none_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign err_multi_o = err_multi_q;
  assign err_none_o  = err_none_q;
  assign multi_cnt_o = multi_cnt_q;
  assign none_cnt_o  = none_cnt_q;

endmodule

// File: tb/tb_sel_arb.sv
// Directed bench for sel_arb: three instances (priority, unique with 2-bit counters, round-robin).
// Inputs change 1ns after the rising edge; outputs are sampled there or 1ns later.
// All instances share stimulus; each scenario starts from reset.
module tb_sel_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        clr_cnt;

  logic [3:0] p_in_ready, u_in_ready, r_in_ready;
  logic       p_out_valid, u_out_valid, r_out_valid;
  logic [7:0] p_out_data, u_out_data, r_out_data;
  logic [1:0] p_out_ch, u_out_ch, r_out_ch;
  logic       p_err_multi, u_err_multi, r_err_multi;
  logic       p_err_none, u_err_none, r_err_none;
  logic [7:0] p_multi_cnt, p_none_cnt, r_multi_cnt, r_none_cnt;
  logic [1:0] u_multi_cnt, u_none_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sel_arb #(.N(4), .W(8), .MODE(0), .FULL_CHK(1), .DEFAULT_VAL(8'hA5), .CNT_W(8)) u_pri (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(p_in_ready),
    .out_valid_o(p_out_valid), .out_data_o(p_out_data), .out_ch_o(p_out_ch), .out_ready_i(out_ready),
    .clr_cnt_i(clr_cnt), .err_multi_o(p_err_multi), .err_none_o(p_err_none),
    .multi_cnt_o(p_multi_cnt), .none_cnt_o(p_none_cnt));

  sel_arb #(.N(4), .W(8), .MODE(1), .FULL_CHK(1), .DEFAULT_VAL(8'hA5), .CNT_W(2)) u_uni (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(u_in_ready),
    .out_valid_o(u_out_valid), .out_data_o(u_out_data), .out_ch_o(u_out_ch), .out_ready_i(out_ready),
    .clr_cnt_i(clr_cnt), .err_multi_o(u_err_multi), .err_none_o(u_err_none),
    .multi_cnt_o(u_multi_cnt), .none_cnt_o(u_none_cnt));

  sel_arb #(.N(4), .W(8), .MODE(2), .FULL_CHK(1), .DEFAULT_VAL(8'hA5), .CNT_W(8)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(r_in_ready),
    .out_valid_o(r_out_valid), .out_data_o(r_out_data), .out_ch_o(r_out_ch), .out_ready_i(out_ready),
    .clr_cnt_i(clr_cnt), .err_multi_o(r_err_multi), .err_none_o(r_err_none),
    .multi_cnt_o(r_multi_cnt), .none_cnt_o(r_none_cnt));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    nchk++; if (p_out_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", p_out_valid); end
    nchk++; if (p_out_data !== 8'hA5) begin nerr++; $display("FAIL rst_data: got %h want a5", p_out_data); end
    nchk++; if (r_out_ch !== 2'd0) begin nerr++; $display("FAIL rst_ch: got %0d want 0", r_out_ch); end
    nchk++; if (u_err_multi !== 1'b0 || u_err_none !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b%b want 00", u_err_multi, u_err_none); end
    nchk++; if (u_multi_cnt !== 2'd0 || u_none_cnt !== 2'd0) begin nerr++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", u_multi_cnt, u_none_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_priority;
    apply_reset();
    in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    nchk++; if (p_in_ready !== 4'b0010) begin nerr++; $display("FAIL pri_in_ready: got %b want 0010", p_in_ready); end
    step();
    nchk++; if (p_out_valid !== 1'b1) begin nerr++; $display("FAIL pri_valid: got %b want 1", p_out_valid); end
    nchk++; if (p_out_ch !== 2'd1) begin nerr++; $display("FAIL pri_ch: got %0d want 1", p_out_ch); end
    nchk++; if (p_out_data !== 8'h22) begin nerr++; $display("FAIL pri_data: got %h want 22", p_out_data); end
    in_valid = 4'b0000;
    step();
    nchk++; if (p_out_valid !== 1'b0) begin nerr++; $display("FAIL pri_drain_valid: got %b want 0", p_out_valid); end
    nchk++; if (p_out_data !== 8'h22 || p_out_ch !== 2'd1) begin nerr++; $display("FAIL pri_drain_hold: got %h/%0d want 22/1", p_out_data, p_out_ch); end
    nchk++; if (p_err_none !== 1'b0) begin nerr++; $display("FAIL pri_no_err: got %b want 0", p_err_none); end
  endtask

  task automatic test_unique;
    apply_reset();
    in_valid = 4'b0110; out_ready = 1'b1;
    #1;
    nchk++; if (u_in_ready !== 4'b0010) begin nerr++; $display("FAIL uni_in_ready: got %b want 0010", u_in_ready); end
    step();
    nchk++; if (u_out_ch !== 2'd1 || u_out_data !== 8'h22) begin nerr++; $display("FAIL uni_grant: got %0d/%h want 1/22", u_out_ch, u_out_data); end
    nchk++; if (u_err_multi !== 1'b1) begin nerr++; $display("FAIL uni_multi_pulse: got %b want 1", u_err_multi); end
    nchk++; if (u_multi_cnt !== 2'd1) begin nerr++; $display("FAIL uni_multi_cnt: got %0d want 1", u_multi_cnt); end
    in_valid = 4'b0000;
    step();
    nchk++; if (u_err_multi !== 1'b0) begin nerr++; $display("FAIL uni_multi_once: got %b want 0", u_err_multi); end
    nchk++; if (u_err_none !== 1'b1 || u_none_cnt !== 2'd1) begin nerr++; $display("FAIL uni_none_full: got %b/%0d want 1/1", u_err_none, u_none_cnt); end
    nchk++; if (u_out_valid !== 1'b0) begin nerr++; $display("FAIL uni_empty: got %b want 0", u_out_valid); end
    step();
    nchk++; if (u_err_none !== 1'b1 || u_none_cnt !== 2'd2) begin nerr++; $display("FAIL uni_none_empty: got %b/%0d want 1/2", u_err_none, u_none_cnt); end
    in_valid = 4'b0001;
    step();
    nchk++; if (u_err_none !== 1'b0 || u_err_multi !== 1'b0) begin nerr++; $display("FAIL uni_clean: got %b%b want 00", u_err_multi, u_err_none); end
    nchk++; if (u_multi_cnt !== 2'd1) begin nerr++; $display("FAIL uni_multi_hold: got %0d want 1", u_multi_cnt); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_d  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    apply_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    nchk++; if (r_in_ready !== 4'b0001) begin nerr++; $display("FAIL rr_first_ready: got %b want 0001", r_in_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      nchk++; if (r_out_ch !== exp_ch[i] || r_out_data !== exp_d[i]) begin nerr++; $display("FAIL rr_seq[%0d]: got %0d/%h want %0d/%h", i, r_out_ch, r_out_data, exp_ch[i], exp_d[i]); end
    end
    // Pointer now at ch0; a sparse request must skip to ch2, then wrap back to ch0.
    in_valid = 4'b0101;
    step();
    nchk++; if (r_out_ch !== 2'd2) begin nerr++; $display("FAIL rr_skip: got %0d want 2", r_out_ch); end
    step();
    nchk++; if (r_out_ch !== 2'd0) begin nerr++; $display("FAIL rr_wrap: got %0d want 0", r_out_ch); end
  endtask

  task automatic test_backpressure;
    apply_reset();
    in_valid = 4'b0001; out_ready = 1'b1;
    step();
    nchk++; if (u_out_valid !== 1'b1 || u_out_data !== 8'h11) begin nerr++; $display("FAIL bp_fill: got %b/%h want 1/11", u_out_valid, u_out_data); end
    out_ready = 1'b0; in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++; if (u_in_ready !== 4'b0000) begin nerr++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, u_in_ready); end
      step();
      nchk++; if (u_out_valid !== 1'b1 || u_out_data !== 8'h11 || u_out_ch !== 2'd0) begin nerr++; $display("FAIL bp_stable[%0d]: got %b/%h/%0d want 1/11/0", i, u_out_valid, u_out_data, u_out_ch); end
      nchk++; if (u_err_multi !== 1'b0 || u_err_none !== 1'b0) begin nerr++; $display("FAIL bp_no_err[%0d]: got %b%b want 00", i, u_err_multi, u_err_none); end
    end
    out_ready = 1'b1;
    #1;
    nchk++; if (u_in_ready !== 4'b0001) begin nerr++; $display("FAIL bp_release_ready: got %b want 0001", u_in_ready); end
    step();
    nchk++; if (u_err_multi !== 1'b1 || u_multi_cnt !== 2'd1) begin nerr++; $display("FAIL bp_release_err: got %b/%0d want 1/1", u_err_multi, u_multi_cnt); end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    in_valid = 4'b0011; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      nchk++; if (u_multi_cnt !== exp_cnt[i]) begin nerr++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, u_multi_cnt, exp_cnt[i]); end
    end
    clr_cnt = 1'b1;
    step();
    nchk++; if (u_multi_cnt !== 2'd1) begin nerr++; $display("FAIL sat_clr_event: got %0d want 1", u_multi_cnt); end
    in_valid = 4'b0001;
    step();
    nchk++; if (u_multi_cnt !== 2'd0) begin nerr++; $display("FAIL sat_clr_plain: got %0d want 0", u_multi_cnt); end
    clr_cnt = 1'b0;
  endtask

  task automatic test_async_reset;
    apply_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    step();
    step();
    nchk++; if (r_out_ch !== 2'd1 || r_out_valid !== 1'b1) begin nerr++; $display("FAIL ar_pre: got %0d/%b want 1/1", r_out_ch, r_out_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    nchk++; if (r_out_valid !== 1'b0 || r_out_data !== 8'hA5 || r_out_ch !== 2'd0) begin nerr++; $display("FAIL ar_immediate: got %b/%h/%0d want 0/a5/0", r_out_valid, r_out_data, r_out_ch); end
    nchk++; if (u_multi_cnt !== 2'd0 || u_err_multi !== 1'b0) begin nerr++; $display("FAIL ar_uni_cleared: got %0d/%b want 0/0", u_multi_cnt, u_err_multi); end
    rst_n = 1'b1;
    step();
    nchk++; if (r_out_valid !== 1'b1 || r_out_ch !== 2'd0 || r_out_data !== 8'h11) begin nerr++; $display("FAIL ar_first_rr: got %b/%0d/%h want 1/0/11", r_out_valid, r_out_ch, r_out_data); end
    step();
    nchk++; if (r_out_ch !== 2'd1) begin nerr++; $display("FAIL ar_second_rr: got %0d want 1", r_out_ch); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_unique();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
